// File: rtl/icache_pkg.sv
// Shared types and defaults for the instruction-cache refill engine.
package icache_pkg;

    // Refill FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } refill_state_e;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 255;

    // Low opcode bits of a full 32-bit instruction; anything else is compressed
    localparam logic [1:0] OPC_32BIT = 2'b11;

    function automatic logic is_32bit_instr(input logic [15:0] halfword);
        return halfword[1:0] == OPC_32BIT;
    endfunction

endpackage

// File: rtl/icache_refill_timer.sv
// Saturating 8-bit wait timer; flags expiry on the cycle the limit is reached.
module icache_refill_timer
    import icache_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Clear on load, otherwise count up while requested and stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // This counting cycle is the TIMEOUT-th one without a response
    assign o_expire = i_count && (r_cnt >= LIMIT);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Refill engine in front of the L1 instruction cache: fetches the missing line
// word by word, plus the following line when a 32-bit instruction may straddle it.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miss_cache,
    input  logic [31:0] miss_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] cache_input,
    output logic        save_to_cache,
    output logic [31:0] cache_waddr,
    output logic        line_valid,
    output logic        refill_busy,
    output logic        refill_done,
    output logic        refill_err
);

    localparam int unsigned       OFFS_W     = $clog2(LINE_WORDS);
    localparam int unsigned       LINE_LSB   = OFFS_W + 2;
    localparam logic [OFFS_W-1:0] LAST_WORD  = OFFS_W'(LINE_WORDS - 1);
    localparam logic [31:0]       LINE_BYTES = 32'(LINE_WORDS * 4);

    refill_state_e     r_state;
    logic [31:0]       r_base;
    logic [OFFS_W-1:0] r_wcnt;
    logic              r_two_lines;

    logic [OFFS_W-1:0] w_wcnt_inc;
    logic [31:0]       w_word_addr;
    logic [31:0]       w_next_word_addr;
    logic [31:0]       w_next_base;
    logic [31:0]       w_miss_base;
    logic              w_miss_two;
    logic              w_tmr_load;
    logic              w_tmr_count;
    logic              w_tmr_expire;
    logic              w_unused;

    // Base is line-aligned, so the word index simply fills the offset bits
    assign w_wcnt_inc       = r_wcnt + OFFS_W'(1);
    assign w_word_addr      = {r_base[31:LINE_LSB], r_wcnt, 2'b00};
    assign w_next_word_addr = {r_base[31:LINE_LSB], w_wcnt_inc, 2'b00};
    assign w_next_base      = r_base + LINE_BYTES;
    assign w_miss_base      = {miss_pc[31:LINE_LSB], {LINE_LSB{1'b0}}};
    assign w_miss_two       = miss_pc[1] & (miss_pc[LINE_LSB-1:2] == LAST_WORD);
    assign w_unused         = miss_pc[0];

    // Timer restarts on every request and runs while waiting for read data
    assign w_tmr_load  = (r_state == ST_REQ);
    assign w_tmr_count = (r_state == ST_WAIT) && !mem_rvalid;

    icache_refill_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_tmr_load),
        .i_count  (w_tmr_count),
        .o_expire (w_tmr_expire)
    );

    // Refill FSM; every output is registered and set on entry to the state that owns it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_base        <= '0;
            r_wcnt        <= '0;
            r_two_lines   <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            cache_input   <= '0;
            save_to_cache <= 1'b0;
            cache_waddr   <= '0;
            line_valid    <= 1'b0;
            refill_busy   <= 1'b0;
            refill_done   <= 1'b0;
            refill_err    <= 1'b0;
        end else begin
            save_to_cache <= 1'b0;
            line_valid    <= 1'b0;
            refill_done   <= 1'b0;
            refill_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (miss_cache) begin
                        r_base      <= w_miss_base;
                        r_wcnt      <= '0;
                        r_two_lines <= w_miss_two;
                        mem_req     <= 1'b1;
                        mem_addr    <= w_miss_base;
                        refill_busy <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_rvalid) begin
                            save_to_cache <= 1'b1;
                            cache_input   <= mem_rdata;
                            cache_waddr   <= w_word_addr;
                            line_valid    <= (r_wcnt == LAST_WORD);
                            r_state       <= ST_WRITE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (mem_rvalid) begin
                        save_to_cache <= 1'b1;
                        cache_input   <= mem_rdata;
                        cache_waddr   <= w_word_addr;
                        line_valid    <= (r_wcnt == LAST_WORD);
                        r_state       <= ST_WRITE;
                    end else if (w_tmr_expire) begin
                        refill_err  <= 1'b1;
                        refill_busy <= 1'b0;
                        r_state     <= ST_ERR;
                    end
                end

                ST_WRITE: begin
                    if (r_wcnt != LAST_WORD) begin
                        r_wcnt   <= w_wcnt_inc;
                        mem_req  <= 1'b1;
                        mem_addr <= w_next_word_addr;
                        r_state  <= ST_REQ;
                    end else if (r_two_lines) begin
                        r_base      <= w_next_base;
                        r_wcnt      <= '0;
                        r_two_lines <= 1'b0;
                        mem_req     <= 1'b1;
                        mem_addr    <= w_next_base;
                        r_state     <= ST_REQ;
                    end else begin
                        refill_done <= 1'b1;
                        refill_busy <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl with a behavioural memory
// responder and an expected write list derived from the missing PC.
module tb_icache_refill_ctrl;

    localparam int unsigned LW  = 4;
    localparam int unsigned TMO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_cache;
    logic [31:0] miss_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] cache_input;
    logic        save_to_cache;
    logic [31:0] cache_waddr;
    logic        line_valid;
    logic        refill_busy;
    logic        refill_done;
    logic        refill_err;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] salt;

    always #5 clk = ~clk;

    icache_refill_ctrl #(
        .LINE_WORDS (LW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .miss_cache    (miss_cache),
        .miss_pc       (miss_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .cache_input   (cache_input),
        .save_to_cache (save_to_cache),
        .cache_waddr   (cache_waddr),
        .line_valid    (line_valid),
        .refill_busy   (refill_busy),
        .refill_done   (refill_done),
        .refill_err    (refill_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address, re-salted per miss
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // One miss: present it, act as memory, score writes against the expected line list.
    // withhold >= 0 never returns data for that request; rst_mid pulls reset while word 1 waits.
    task automatic run_miss(input logic [31:0] pc, input int gmin, input int gmax, input int rmax,
                            input int withhold, input bit rvg, input bit toggle,
                            input bit rst_mid, input bit chk_lat);
        logic [31:0] exp_addr[$];
        logic [31:0] base;
        logic [31:0] req_addr;
        int          nlines;
        int          n_wr, n_done, n_errp, req_idx, gnt_wait, rv_wait, lat;
        int          exp_wr, exp_done, exp_errp;
        bit          outstanding, in_req, finished, quiet_bad;

        base   = pc & ~32'(LW * 4 - 1);
        nlines = (pc[1] && (((pc >> 2) % LW) == LW - 1)) ? 2 : 1;
        for (int l = 0; l < nlines; l++)
            for (int w = 0; w < int'(LW); w++)
                exp_addr.push_back(base + 32'(l * LW * 4 + w * 4));
        salt = $urandom;

        n_wr = 0; n_done = 0; n_errp = 0; req_idx = 0; gnt_wait = 0; rv_wait = 0; lat = -1;
        outstanding = 0; in_req = 0; finished = 0; quiet_bad = 0; req_addr = '0;

        if (withhold >= 0) begin
            exp_wr = withhold; exp_done = 0; exp_errp = 1;
        end else if (rst_mid) begin
            exp_wr = 1; exp_done = 0; exp_errp = 0;
        end else begin
            exp_wr = int'(LW) * nlines; exp_done = 1; exp_errp = 0;
        end

        @(negedge clk);
        miss_cache = 1'b1;
        miss_pc    = pc;

        for (int k = 1; k < 1500 && !finished; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy", refill_busy, 1);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (toggle) begin
                miss_cache = 1'($urandom_range(0, 1));
                miss_pc    = $urandom;
            end else begin
                miss_cache = 1'b0;
            end

            if (save_to_cache) begin
                if (n_wr < exp_addr.size()) begin
                    chk("waddr", cache_waddr, exp_addr[n_wr]);
                    chk("wdata", cache_input, mem_word(exp_addr[n_wr]));
                    chk("line_valid", line_valid, (n_wr % LW) == LW - 1);
                end else begin
                    chk("extra_write", 1, 0);
                end
                n_wr++;
            end else if (line_valid) begin
                chk("lv_without_write", 1, 0);
            end
            if (refill_done) begin n_done++; lat = k + 1; finished = 1; end
            if (refill_err)  begin n_errp++; finished = 1; end
            // A stale miss held into DONE/ERR must not restart a refill
            if (finished && toggle) miss_cache = 1'b1;

            if (!finished) begin
                if (outstanding && rst_mid && req_idx == 2) begin
                    miss_cache = 1'b0;
                    #2 reset = 1'b0;
                    #1;
                    chk("rst_mem_req", mem_req, 0);
                    chk("rst_busy", refill_busy, 0);
                    chk("rst_addrs", mem_addr | cache_waddr | cache_input, 0);
                    chk("rst_strobes", {save_to_cache, line_valid, refill_done, refill_err}, 0);
                    @(negedge clk);
                    reset    = 1'b1;
                    finished = 1;
                end else if (outstanding) begin
                    if (req_idx - 1 != withhold) begin
                        if (rv_wait == 0) begin
                            mem_rvalid  = 1'b1;
                            mem_rdata   = mem_word(req_addr);
                            outstanding = 0;
                        end else begin
                            rv_wait--;
                        end
                    end
                end else if (mem_req) begin
                    if (!in_req) begin
                        in_req   = 1;
                        req_addr = mem_addr;
                        gnt_wait = $urandom_range(gmin, gmax);
                        if (req_idx < exp_addr.size()) chk("req_addr", mem_addr, exp_addr[req_idx]);
                        else chk("extra_req", 1, 0);
                    end else begin
                        chk("addr_stable", mem_addr, req_addr);
                    end
                    if (gnt_wait == 0) begin
                        mem_gnt = 1'b1;
                        in_req  = 0;
                        req_idx++;
                        if (rvg && (req_idx - 1 != withhold)) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = mem_word(req_addr);
                        end else begin
                            outstanding = 1;
                            rv_wait     = $urandom_range(0, rmax);
                        end
                    end else begin
                        gnt_wait--;
                    end
                end else begin
                    // Stray read data while nothing is pending must be ignored
                    mem_rvalid = ($urandom_range(0, 3) == 0);
                end
            end
        end
        if (!finished) chk("no_completion", 0, 1);

        for (int q = 0; q < 4; q++) begin
            @(negedge clk);
            miss_cache = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            quiet_bad  = quiet_bad | mem_req | save_to_cache | refill_busy;
        end
        chk("quiet", quiet_bad, 0);
        chk("nwrites", n_wr, exp_wr);
        chk("ndone", n_done, exp_done);
        chk("nerr", n_errp, exp_errp);
        // Miss cycle counts as the first, refill_done's cycle as the last
        if (chk_lat) chk("latency", lat, 2 + 3 * LW * nlines);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          gm, rm;
        reset      = 1'b0;
        miss_cache = 1'b0;
        miss_pc    = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #3;
        chk("reset_ctl", {mem_req, save_to_cache, line_valid, refill_busy, refill_done, refill_err}, 0);
        chk("reset_data", mem_addr | cache_input | cache_waddr, 0);
        @(negedge clk);
        reset = 1'b1;

        run_miss(32'h0000_0104, 0, 0, 0, -1, 0, 0, 0, 1);
        run_miss(32'h0000_010E, 0, 0, 0, -1, 0, 0, 0, 1);
        run_miss(32'hFFFF_FFFE, 0, 0, 0, -1, 0, 0, 0, 1);
        run_miss(32'h0000_0104, 0, 0, 0,  2, 0, 0, 0, 0);
        run_miss(32'h0000_0208, 0, 2, 2, -1, 0, 0, 0, 0);
        run_miss(32'h0000_0300, 0, 0, 0, -1, 0, 0, 1, 0);
        run_miss(32'h0000_0310, 0, 0, 0, -1, 0, 0, 0, 1);
        run_miss(32'h0000_4A0E, 3, 3, 0, -1, 1, 1, 0, 0);

        for (int i = 0; i < 25; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 2) == 0) pc[3:0] = 4'hE;
            gm = $urandom_range(0, 3);
            rm = $urandom_range(0, 3);
            run_miss(pc, 0, gm, rm, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
